// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
package multdiv_pkg;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/multdiv_add_sub_w.sv
// W-bit adder/subtractor shared by the multiply and divide datapaths.
module add_sub_w #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);
  assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: one step per cycle on operand magnitudes,
// sign applied in the final RUN cycle so latency is always WIDTH+1.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op, r_neg, r_dz, r_ovf;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo, r_mag;
  logic [WIDTH-1:0] r_result;
  logic             r_exc, r_rdy, r_busy;

  logic             w_start;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_add_a, w_add_b, w_sum, w_mpart, w_shift;
  logic             w_div_ok;
  logic [2*WIDTH-1:0] w_prod, w_sprod;
  logic [WIDTH-1:0] w_q;
  logic             w_mult_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // r_hi is the partial product (multiply) or partial remainder (divide);
  // r_lo holds the multiplier being consumed or the dividend/quotient.
  assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_add_a = (r_op == OP_DIV) ? w_shift : r_hi;
  assign w_add_b = {1'b0, r_mag};

  add_sub_w #(.W(WIDTH + 1)) u_add_sub (
    .i_a  (w_add_a),
    .i_b  (w_add_b),
    .i_sub(r_op == OP_DIV),
    .o_y  (w_sum)
  );

  assign w_mpart  = r_lo[0] ? w_sum : r_hi;
  assign w_div_ok = ~w_sum[WIDTH];

  assign w_prod     = {r_hi[WIDTH-1:0], r_lo};
  assign w_sprod    = r_neg ? -w_prod : w_prod;
  assign w_mult_exc = ~((&w_sprod[2*WIDTH-1:WIDTH-1]) | ~(|w_sprod[2*WIDTH-1:WIDTH-1]));
  assign w_q        = r_neg ? -r_lo : r_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MULT;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mag    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= ctrl_MULT ? OP_MULT : OP_DIV;
            r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz    <= (data_operandB == '0);
            r_ovf   <= (data_operandA == MIN_NEG) && (&data_operandB);
            r_hi    <= '0;
            r_mag   <= ctrl_MULT ? w_a_mag : w_b_mag;
            r_lo    <= ctrl_MULT ? w_b_mag : w_a_mag;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
            if (r_op == OP_MULT) begin
              r_result <= w_sprod[WIDTH-1:0];
              r_exc    <= w_mult_exc;
            end else if (r_dz || r_ovf) begin
              r_result <= '0;
              r_exc    <= 1'b1;
            end else begin
              r_result <= w_q;
              r_exc    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == OP_MULT) begin
              r_hi <= {1'b0, w_mpart[WIDTH:1]};
              r_lo <= {w_mpart[0], r_lo[WIDTH-1:1]};
            end else begin
              r_hi <= w_div_ok ? w_sum : w_shift;
              r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 4..64.
REQ-002 clock  input  1  master clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_operandA  input  WIDTH  signed multiplicand or dividend; sampled only on an accepted start.
REQ-005 data_operandB  input  WIDTH  signed multiplier or divisor; sampled only on an accepted start.
REQ-006 ctrl_MULT  input  1  single-cycle start pulse for a signed multiply.
REQ-007 ctrl_DIV  input  1  single-cycle start pulse for a signed divide.
REQ-008 data_result  output  WIDTH  product (low WIDTH bits) or truncated quotient.
REQ-009 data_exception  output  1  overflow or divide fault for the current result; valid while data_resultRDY is high.
REQ-010 data_resultRDY  output  1  one-cycle pulse marking a completed operation.
REQ-011 busy  output  1  high while an operation is iterating; starts are ignored while high.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on an accepted start.
- RUN -> DONE when the iteration counter reaches WIDTH.
- DONE -> IDLE when no start is accepted.
REQ-013 A start is accepted at a rising edge where (ctrl_MULT or ctrl_DIV) is high and the state is IDLE or DONE; operands and opcode are latched at that edge.
REQ-014 ctrl_MULT and ctrl_DIV both high at an accepted start: multiply is performed and ctrl_DIV is ignored.
REQ-015 Starts arriving while busy=1 are dropped silently; latched operands and in-flight state are unaffected.
REQ-016 busy=1 exactly in RUN; data_resultRDY=1 exactly in DONE.
REQ-017 Latency is fixed at WIDTH+1 cycles for both operations, including fault cases: start accepted at edge N -> data_resultRDY high during the cycle after edge N+WIDTH+1.
REQ-018 Multiply: iterative shift-add over WIDTH steps, one step per RUN cycle, forming a 2*WIDTH-bit signed product.
- data_result is the low WIDTH bits of the product.
- data_exception=1 when the upper WIDTH+1 product bits are not all equal.
REQ-019 Divide: restoring division on operand magnitudes, one quotient bit per RUN cycle; the quotient is negated when the operand signs differ (truncation toward zero).
REQ-020 Divide by zero: data_result=0, data_exception=1.
REQ-021 Most-negative divided by -1: data_result=0, data_exception=1.
REQ-022 data_result and data_exception hold their last values from DONE until the next DONE; they are not cleared in IDLE.
REQ-023 Back-to-back operation: a start accepted during DONE enters RUN at the next edge; that cycle's data_resultRDY pulse still completes.
REQ-024 The iteration counter is ceil(log2(WIDTH+1)) bits wide and never wraps within an operation.

Reset
REQ-025 Reset high at a rising edge forces the following, overriding any start in the same cycle:
- state=IDLE;
- counter=0;
- data_result=0;
- data_exception=0;
- data_resultRDY=0;
- busy=0.
REQ-026 Reset during RUN or DONE abandons the operation; no data_resultRDY pulse is produced for it.
REQ-027 Reset releases in IDLE; a start may be accepted at the first edge with reset low.

Structure
REQ-028 Shared package multdiv_pkg holds:
- the FSM state encoding (2 bits);
- opcode constants OP_MULT and OP_DIV;
- default WIDTH.
REQ-029 One sub-module, add_sub_w: a parametrised WIDTH+1-bit adder/subtractor shared by the multiply and divide datapaths.

Verification
REQ-030 WIDTH=32, reset pulse, then MULT with A=7, B=-6 -> after 33 cycles: RDY pulse, result=-42, exception=0, busy low.
REQ-031 WIDTH=32, MULT with A=0x40000000, B=4 -> result=0, exception=1. Repeat with A=-1, B=-1 -> result=1, exception=0.
REQ-032 WIDTH=32, DIV cases:
- A=-17, B=5 -> result=-3, exception=0.
- A=9, B=0 -> result=0, exception=1.
- A=0x80000000, B=-1 -> result=0, exception=1.
REQ-033 WIDTH=32, second ctrl_DIV pulse 10 cycles after a MULT start -> ignored; exactly one RDY pulse, carrying the multiply result. Then a new start issued during the DONE cycle -> second RDY exactly 33 cycles later.
REQ-034 WIDTH=32, reset asserted 15 cycles into a DIV -> no RDY pulse; all outputs 0; busy 0. A following MULT 3x3 -> result=9.
REQ-035 WIDTH=8, random signed operands checked against a reference model; RDY latency exactly 9 cycles on every operation.
